// File: rtl/vga_sprite_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_sprite_ctrl_if
//   Host command port for vga_sprite_ctrl. It is a valid/ready channel, and a
//   command moves across it only in a cycle where cmd_valid and cmd_ready are
//   both high.
//
//   Signals:
//     cmd_valid  host -> ctrl   command valid
//     cmd_ready  ctrl -> host   controller can accept a command
//     cmd_op     host -> ctrl   0 = SET_X, 1 = SET_Y, 2 = SET_SPEED, 3 = RUN
//     cmd_arg    host -> ctrl   command argument (10 bits)
//
//   Modports:
//     master  host side
//     slave   controller side
// ----------------------------------------------------------------------------
interface vga_sprite_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [9:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/vga_sprite_ctrl.sv
// ----------------------------------------------------------------------------
// vga_sprite_ctrl
//   Frame-synchronous position controller for the moving square on the
//   800x600 VGA path. Host commands land only in shadow registers. On each
//   vertical-blank strobe the controller does three things in order:
//     1. It commits the pending shadows to the live registers.
//     2. It advances the square, bouncing off the edges.
//     3. It presents registered spr_x/spr_y together with a one-cycle
//        spr_upd pulse.
//   The drawn square therefore never tears.
//
//   Ports:
//     clk          pixel clock (50 MHz)
//     rst_n        asynchronous, active-low reset
//     frame_pulse  one-cycle strobe at the start of vertical blank
//     cmd          host command channel (vga_sprite_ctrl_if.slave)
//     spr_x        square left edge, active-area coordinates
//     spr_y        square top edge
//     spr_upd      one-cycle pulse when new spr_x/spr_y are valid
//     running      motion enabled
//
//   Build option:
//     SPR_WRAP_EN  when defined, the square wraps at the edges instead of
//                  bouncing, and the direction never flips.
// ----------------------------------------------------------------------------
module vga_sprite_ctrl #(
    parameter int H_ACT = 800,
    parameter int V_ACT = 600,
    parameter int SPR_W = 31,
    parameter int SPR_H = 31,
    parameter int X0    = 385,
    parameter int Y0    = 285
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_pulse,
    vga_sprite_ctrl_if.slave     cmd,
    output logic [9:0]           spr_x,
    output logic [9:0]           spr_y,
    output logic                 spr_upd,
    output logic                 running
);

    localparam logic [9:0] XMAX   = 10'(H_ACT - SPR_W);
    localparam logic [9:0] YMAX   = 10'(V_ACT - SPR_H);
    localparam logic [9:0] X_RST  = 10'(X0);
    localparam logic [9:0] Y_RST  = 10'(Y0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_SET_X     = 2'd0,
        OP_SET_Y     = 2'd1,
        OP_SET_SPEED = 2'd2,
        OP_RUN       = 2'd3
    } op_t;

    // Result of advancing one axis by one frame.
    typedef struct packed {
        logic [9:0] pos;
        logic       fwd;    // 1 = right/down, 0 = left/up
    } axis_t;

    // One-frame motion of a single axis. The 11-bit intermediates keep
    // pos + spd from overflowing before it is compared with the limit.
    // A speed of zero freezes the axis and leaves its direction unchanged.
    function automatic axis_t step_axis(
        input logic [9:0] pos,
        input logic [3:0] spd,
        input logic       fwd,
        input logic [9:0] lim
    );
        logic [10:0] pos_w;
        logic [10:0] spd_w;
        logic [10:0] lim_w;
        logic [10:0] sum;
        logic [10:0] dif;
        axis_t       r;
        pos_w = {1'b0, pos};
        spd_w = {7'd0, spd};
        lim_w = {1'b0, lim};
        sum   = pos_w + spd_w;
        dif   = pos_w - spd_w;
        r.pos = pos;
        r.fwd = fwd;
        if (spd != 4'd0) begin
`ifdef SPR_WRAP_EN
            if (fwd) begin
                r.pos = (sum > lim_w) ? 10'd0 : sum[9:0];
            end else begin
                r.pos = (pos_w < spd_w) ? lim : dif[9:0];
            end
`else
            if (fwd) begin
                if (sum >= lim_w) begin
                    r.pos = lim;
                    r.fwd = 1'b0;
                end else begin
                    r.pos = sum[9:0];
                end
            end else begin
                if (pos_w <= spd_w) begin
                    r.pos = 10'd0;
                    r.fwd = 1'b1;
                end else begin
                    r.pos = dif[9:0];
                end
            end
`endif
        end
        return r;
    endfunction

    state_t     state_q,   state_d;

    // Shadow registers and their pending flags.
    logic [9:0] sh_x_q,    sh_x_d;
    logic [9:0] sh_y_q,    sh_y_d;
    logic [3:0] sh_dx_q,   sh_dx_d;
    logic [3:0] sh_dy_q,   sh_dy_d;
    logic       sh_run_q,  sh_run_d;
    logic       pend_x_q,  pend_x_d;
    logic       pend_y_q,  pend_y_d;
    logic       pend_spd_q, pend_spd_d;
    logic       pend_run_q, pend_run_d;

    // Live registers.
    logic [9:0] pos_x_q,   pos_x_d;
    logic [9:0] pos_y_q,   pos_y_d;
    logic [3:0] dx_q,      dx_d;
    logic [3:0] dy_q,      dy_d;
    logic       dir_x_q,   dir_x_d;
    logic       dir_y_q,   dir_y_d;
    logic       run_q,     run_d;

    // A position committed this frame is output unmoved.
    logic       fresh_x_q, fresh_x_d;
    logic       fresh_y_q, fresh_y_d;

    // Registered outputs.
    logic [9:0] spr_x_q,   spr_x_d;
    logic [9:0] spr_y_q,   spr_y_d;
    logic       spr_upd_q, spr_upd_d;

    logic       cmd_ready;
    logic       accept;
    axis_t      nx;
    axis_t      ny;

    assign cmd.cmd_ready = cmd_ready;
    assign spr_x         = spr_x_q;
    assign spr_y         = spr_y_q;
    assign spr_upd       = spr_upd_q;
    assign running       = run_q;

    always_comb begin
        state_d    = state_q;
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_dx_d    = sh_dx_q;
        sh_dy_d    = sh_dy_q;
        sh_run_d   = sh_run_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_spd_d = pend_spd_q;
        pend_run_d = pend_run_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        run_d      = run_q;
        fresh_x_d  = fresh_x_q;
        fresh_y_d  = fresh_y_q;
        spr_x_d    = spr_x_q;
        spr_y_d    = spr_y_q;
        spr_upd_d  = 1'b0;

        cmd_ready  = (state_q == IDLE);
        accept     = cmd.cmd_valid && cmd_ready;
        nx         = step_axis(pos_x_q, dx_q, dir_x_q, XMAX);
        ny         = step_axis(pos_y_q, dy_q, dir_y_q, YMAX);

        // Commands are accepted only in IDLE. A command that arrives together
        // with frame_pulse is therefore already pending when APPLY runs.
        if (accept) begin
            case (op_t'(cmd.cmd_op))
                OP_SET_X: begin
                    sh_x_d   = (cmd.cmd_arg > XMAX) ? XMAX : cmd.cmd_arg;
                    pend_x_d = 1'b1;
                end
                OP_SET_Y: begin
                    sh_y_d   = (cmd.cmd_arg > YMAX) ? YMAX : cmd.cmd_arg;
                    pend_y_d = 1'b1;
                end
                OP_SET_SPEED: begin
                    sh_dx_d    = cmd.cmd_arg[3:0];
                    sh_dy_d    = cmd.cmd_arg[7:4];
                    pend_spd_d = 1'b1;
                end
                default: begin
                    sh_run_d   = cmd.cmd_arg[0];
                    pend_run_d = 1'b1;
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                if (frame_pulse) state_d = APPLY;
            end
            APPLY: begin
                if (pend_x_q)   pos_x_d = sh_x_q;
                if (pend_y_q)   pos_y_d = sh_y_q;
                if (pend_spd_q) begin
                    dx_d = sh_dx_q;
                    dy_d = sh_dy_q;
                end
                if (pend_run_q) run_d = sh_run_q;
                fresh_x_d  = pend_x_q;
                fresh_y_d  = pend_y_q;
                pend_x_d   = 1'b0;
                pend_y_d   = 1'b0;
                pend_spd_d = 1'b0;
                pend_run_d = 1'b0;
                state_d    = STEP;
            end
            STEP: begin
                // The outputs are loaded here, so the new position and the
                // spr_upd pulse both appear during DONE.
                if (run_q && !fresh_x_q) begin
                    pos_x_d = nx.pos;
                    dir_x_d = nx.fwd;
                end
                if (run_q && !fresh_y_q) begin
                    pos_y_d = ny.pos;
                    dir_y_d = ny.fwd;
                end
                spr_x_d   = (run_q && !fresh_x_q) ? nx.pos : pos_x_q;
                spr_y_d   = (run_q && !fresh_y_q) ? ny.pos : pos_y_q;
                spr_upd_d = 1'b1;
                state_d   = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_dx_q    <= '0;
            sh_dy_q    <= '0;
            sh_run_q   <= 1'b0;
            pend_x_q   <= 1'b0;
            pend_y_q   <= 1'b0;
            pend_spd_q <= 1'b0;
            pend_run_q <= 1'b0;
            pos_x_q    <= X_RST;
            pos_y_q    <= Y_RST;
            dx_q       <= 4'd1;
            dy_q       <= 4'd1;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            run_q      <= 1'b0;
            fresh_x_q  <= 1'b0;
            fresh_y_q  <= 1'b0;
            spr_x_q    <= X_RST;
            spr_y_q    <= Y_RST;
            spr_upd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_x_q     <= sh_x_d;
            sh_y_q     <= sh_y_d;
            sh_dx_q    <= sh_dx_d;
            sh_dy_q    <= sh_dy_d;
            sh_run_q   <= sh_run_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            pend_spd_q <= pend_spd_d;
            pend_run_q <= pend_run_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            run_q      <= run_d;
            fresh_x_q  <= fresh_x_d;
            fresh_y_q  <= fresh_y_d;
            spr_x_q    <= spr_x_d;
            spr_y_q    <= spr_y_d;
            spr_upd_q  <= spr_upd_d;
        end
    end

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_sprite_ctrl
//   Bench for vga_sprite_ctrl.
//   - Stimulus tasks issue commands and frames. At the same time they update
//     a behavioural model of the shadow/commit/move rules and push the
//     expected frame result into a queue.
//   - A monitor pops one entry on every spr_upd pulse and compares it with
//     the outputs. Between pulses the monitor checks that the outputs hold
//     still.
// ----------------------------------------------------------------------------
module tb_vga_sprite_ctrl;
    localparam int XMAX = 769;
    localparam int YMAX = 569;
    localparam int X0   = 385;
    localparam int Y0   = 285;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_pulse = 1'b0;
    logic [9:0] spr_x;
    logic [9:0] spr_y;
    logic       spr_upd;
    logic       running;

    vga_sprite_ctrl_if cmd_if();

    vga_sprite_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_pulse (frame_pulse),
        .cmd         (cmd_if),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_upd     (spr_upd),
        .running     (running)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int y;
        int run;
        int at;
    } exp_t;
    exp_t q[$];

    // Reference model state
    int m_x, m_y, m_dx, m_dy, m_run;
    bit m_rx, m_dn;
    int s_x, s_y, s_dx, s_dy, s_run;
    bit p_x, p_y, p_s, p_r;
    int cur_x = X0;
    int cur_y = Y0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1; m_run = 0;
        m_rx = 1'b1; m_dn = 1'b1;
        p_x = 0; p_y = 0; p_s = 0; p_r = 0;
        q.delete();
        cur_x = X0; cur_y = Y0;
    endtask

    task automatic model_cmd(input int op, input int arg);
        case (op)
            0: begin s_x = (arg > XMAX) ? XMAX : arg; p_x = 1; end
            1: begin s_y = (arg > YMAX) ? YMAX : arg; p_y = 1; end
            2: begin s_dx = arg % 16; s_dy = (arg / 16) % 16; p_s = 1; end
            default: begin s_run = arg % 2; p_r = 1; end
        endcase
    endtask

    task automatic move(inout int pos, input int spd, inout bit fwd, input int lim);
        int n;
        if (spd == 0) return;
        n = fwd ? pos + spd : pos - spd;
`ifdef SPR_WRAP_EN
        if (n > lim) n = 0;
        else if (n < 0) n = lim;
`else
        if (fwd && n >= lim) begin n = lim; fwd = 1'b0; end
        else if (!fwd && n <= 0) begin n = 0; fwd = 1'b1; end
`endif
        pos = n;
    endtask

    task automatic model_frame(input int at);
        bit fx, fy;
        exp_t e;
        fx = p_x; fy = p_y;
        if (p_x) m_x = s_x;
        if (p_y) m_y = s_y;
        if (p_s) begin m_dx = s_dx; m_dy = s_dy; end
        if (p_r) m_run = s_run;
        p_x = 0; p_y = 0; p_s = 0; p_r = 0;
        if (m_run != 0) begin
            if (!fx) move(m_x, m_dx, m_rx, XMAX);
            if (!fy) move(m_y, m_dy, m_dn, YMAX);
        end
        e.x = m_x; e.y = m_y; e.run = m_run; e.at = at;
        q.push_back(e);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (spr_upd) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upd: got spr_upd=1, expected no update (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("upd_x", int'(spr_x), e.x);
                    chk("upd_y", int'(spr_y), e.y);
                    chk("upd_running", int'(running), e.run);
                    chk("upd_latency", cyc, e.at);
                    cur_x = e.x;
                    cur_y = e.y;
                end
            end else begin
                chk("hold_x", int'(spr_x), cur_x);
                chk("hold_y", int'(spr_y), cur_y);
            end
        end
    end

    // Called #1 after a rising edge; returns the number of cycles waited for ready.
    task automatic send_cmd(input int op, input int arg, output int waits);
        bit done;
        done = 0;
        waits = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'(op);
        cmd_if.cmd_arg   = 10'(arg);
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_if.cmd_ready) done = 1;
            else waits++;
            @(posedge clk); #1;
        end
        cmd_if.cmd_valid = 1'b0;
        if (done) model_cmd(op, arg);
        else begin
            checks++; errors++;
            $display("FAIL cmd_timeout: got cmd_ready=0 for 20 cycles, expected acceptance");
        end
    endtask

    task automatic cmd(input int op, input int arg);
        int w;
        send_cmd(op, arg, w);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !cmd_if.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Frame strobe, optionally with a command presented in the same cycle.
    task automatic frame(input bit with_cmd, input int op, input int arg);
        wait_idle();
        frame_pulse = 1'b1;
        if (with_cmd) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = 2'(op);
            cmd_if.cmd_arg   = 10'(arg);
        end
        @(posedge clk); #1;
        frame_pulse = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        if (with_cmd) model_cmd(op, arg);
        model_frame(cyc + 2);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending updates, expected 0", q.size());
        end
    endtask

    initial begin
        int w;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_arg   = 10'd0;
        s_x = 0; s_y = 0; s_dx = 0; s_dy = 0; s_run = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(spr_x), X0);
        chk("rst_y", int'(spr_y), Y0);
        chk("rst_running", int'(running), 0);
        chk("rst_upd", int'(spr_upd), 0);
        chk("rst_ready", int'(cmd_if.cmd_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three idle frames
        repeat (3) frame(0, 0, 0);
        drain();
        chk("idle_x", int'(spr_x), 385);
        chk("idle_y", int'(spr_y), 285);
        chk("idle_running", int'(running), 0);

        // Run with dx=1, dy=2
        cmd(3, 1);
        cmd(2, 'h21);
        frame(0, 0, 0); drain();
        chk("run1_x", int'(spr_x), 386);
        chk("run1_y", int'(spr_y), 287);
        frame(0, 0, 0); drain();
        chk("run2_x", int'(spr_x), 387);
        chk("run2_y", int'(spr_y), 289);

        // Edge behaviour on x, y frozen
        cmd(0, 765);
        cmd(2, 4);
        frame(0, 0, 0); drain();
        chk("setx_unmoved", int'(spr_x), 765);
        chk("frozen_y", int'(spr_y), 289);
        frame(0, 0, 0); drain();
        chk("edge_x", int'(spr_x), 769);
        frame(0, 0, 0); drain();
`ifdef SPR_WRAP_EN
        chk("edge_next_x", int'(spr_x), 0);
`else
        chk("edge_next_x", int'(spr_x), 765);
`endif

        // Clamp and last-wins
        cmd(3, 0);
        cmd(0, 1000);
        frame(0, 0, 0); drain();
        chk("clamp_x", int'(spr_x), 769);
        cmd(0, 5);
        cmd(0, 7);
        frame(0, 0, 0); drain();
        chk("last_wins_x", int'(spr_x), 7);
        cmd(1, 1023);
        frame(0, 0, 0); drain();
        chk("clamp_y", int'(spr_y), 569);

        // Command coincident with frame_pulse
        frame(1, 1, 100); drain();
        chk("coincident_y", int'(spr_y), 100);

        // Command held through the busy window; stray frame_pulse ignored
        frame(0, 0, 0);
        frame_pulse = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = 2'd1;
        cmd_if.cmd_arg = 10'd200;
        chk("ready_in_apply", int'(cmd_if.cmd_ready), 0);
        @(posedge clk); #1;
        frame_pulse = 1'b0;
        send_cmd(1, 200, w);
        chk("ready_gap", w + 1, 3);
        drain();
        chk("held_not_yet", int'(spr_y), 100);
        frame(0, 0, 0); drain();
        chk("held_committed_y", int'(spr_y), 200);

`ifdef SPR_WRAP_EN
        cmd(0, 767);
        cmd(2, 4);
        cmd(3, 1);
        frame(0, 0, 0); drain();
        frame(0, 0, 0); drain();
        chk("wrap_x", int'(spr_x), 0);
`endif

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                int op, arg;
                op = int'($urandom_range(0, 3));
                arg = int'($urandom_range(0, 1023));
                if (op == 3 && $urandom_range(0, 3) != 0) arg = arg | 1;
                if (op <= 1 && $urandom_range(0, 2) == 0) arg = int'($urandom_range(0, 12));
                cmd(op, arg);
            end
            if ($urandom_range(0, 3) == 0)
                frame(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
            else
                frame(0, 0, 0);
        end
        drain();

        // Reset asserted in STEP
        cmd(0, 100);
        cmd(1, 50);
        frame(0, 0, 0); drain();
        chk("pre_reset_x", int'(spr_x), 100);
        frame(0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("step_rst_x", int'(spr_x), X0);
        chk("step_rst_y", int'(spr_y), Y0);
        chk("step_rst_running", int'(running), 0);
        chk("step_rst_upd", int'(spr_upd), 0);
        chk("step_rst_ready", int'(cmd_if.cmd_ready), 1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(0, 0, 0); drain();
        chk("post_rst_x", int'(spr_x), X0);

        // Pending command discarded by reset
        cmd(0, 50);
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(0, 0, 0); drain();
        chk("discard_x", int'(spr_x), X0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1);
    end
endmodule
